instr_word_encoder: RTL
=======================

Name: instr_word_encoder

Overview:
Inverse of the single-cycle controller's instruction decoder. It accepts decoded instruction fields (format, function, rd, rs1, rs2, imm) over a valid/ready handshake and packs them into 32-bit instruction words in the processor's encoding. It buffers the words in a small FIFO and emits them with a word address for writing into instruction memory. It sits between the test/boot loader and the instruction-memory write port.

Parameters:
ADDR_W, 12, width of instruction-memory word address counter
FIFO_DEPTH, 2, output buffer entries (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  field set present
in_ready  out  1  encoder can accept
fmt  in  4  format code (becomes word[3:0])
fn  in  4  function code (becomes word[7:4])
rd  in  4  destination register
rs1  in  4  source register 1
rs2  in  4  source register 2
imm  in  16  immediate
out_valid  out  1  head word valid
out_ready  in  1  memory port accepts head word
out_word  out  32  encoded instruction
out_addr  out  ADDR_W  word address for out_word
base_load  in  1  load address counter
base_addr  in  ADDR_W  value loaded by base_load
err_flag  out  1  sticky illegal-format flag
err_clr  in  1  clears err_flag and err_count
err_count  out  8  saturating illegal-format count
instr_count  out  16  words emitted (see Optional Feature)

Behaviour:
- Reset values: FIFO empty, out_valid=0, out_word=0, out_addr=0, err_flag=0, err_count=0, instr_count=0. in_ready=1 one cycle after reset_n deasserts.
- Reset mid-operation: all buffered words are discarded immediately, with no write on that cycle.
- Handshakes: input transfer when in_valid&in_ready at a rising edge; output transfer when out_valid&out_ready. in_valid need not wait on in_ready.
- in_ready is registered: it is 1 iff FIFO count < FIFO_DEPTH after the current edge's push/pop. When full, there is no same-cycle pass-through.
- Latency: a word accepted at edge t is visible at the FIFO head no earlier than after edge t (out_valid=1 in cycle t+1 if FIFO was empty). Words leave in acceptance order.
- Encoding, where opcode = {fn,fmt} in [7:0]; unused bits are 0:
  - ALU_R 0000, CMP_R 0010: [31:28]=rd, [27:24]=rs1, [23:20]=rs2, [19:8]=0.
  - ALU_I 1000, CMP_I 1010, LW 1001, JAL 1011: [31:28]=rd, [27:24]=rs1, [23:8]=imm.
  - ALU_I with fn=1011 (MVHI): [31:28]=rd, [27:24]=0, [23:8]=imm.
  - SW 0101, BRANCH 0110: [31:28]=rs1, [27:24]=rs2, [23:8]=imm. BRANCH with rs2=0 is legal (compare-with-zero form).
- Illegal fmt (any other code): the transfer is still accepted (handshake completes), nothing is pushed, err_flag is set, and err_count increments, saturating at 255.
  - err_clr zeroes both. If err_clr and a new error coincide, the error wins: flag=1, count=1.
- Address counter: out_addr is the address of the head word. It increments by 1 on each output transfer and wraps from 2^ADDR_W-1 to 0.
  - base_load loads base_addr. If base_load coincides with a pop, base_load wins (counter=base_addr, no increment).
  - Buffered words keep their order and take addresses from the counter as they pop.
- FIFO states: EMPTY (out_valid=0), PARTIAL, FULL (in_ready=0). Simultaneous push and pop in PARTIAL leaves the count unchanged.
- out_word holds stable while out_valid=1 and out_ready=0.

Optional Feature:
ENC_COUNT_EN:
- Defined: instr_count increments by 1 on every output transfer and wraps at 16 bits. It is reset to 0 by reset_n only; base_load and err_clr do not affect it.
- Undefined: instr_count is tied to 0 and no counter logic is built. The port exists either way.

Test Plan:
- ALU_R fmt=0000 fn=0010 rd=3 rs1=4 rs2=5, base_load 0x010, out_ready=1 -> out_word=0x34500020, out_addr=0x010, out_valid the cycle after acceptance.
- MVHI fmt=1000 fn=1011 rd=7 rs1=9 imm=0xBEEF -> out_word=0x70BEEFB8 (rs1 field forced 0).
- SW fmt=0101 fn=0 rs1=2 rs2=6 imm=0x0004 then BRANCH fmt=0110 fn=0001 rs1=1 rs2=0 imm=0xFFFE -> 0x26000405 then 0x10FFFE16, addresses consecutive.
- out_ready=0 while streaming 3 words (FIFO_DEPTH=2) -> in_ready drops after the 2nd accept and out_word holds. Release -> 3 writes in order at addr n, n+1, n+2.
- fmt=0111 -> no output, err_flag=1, err_count=1. 300 illegal words -> err_count=255. err_clr with a simultaneous error -> count=1.
- base_addr=2^ADDR_W-1 with 2 words -> addresses 0xFFF then 0x000. With ENC_COUNT_EN, instr_count=2; without it, 0. Assert reset_n with 2 buffered words -> out_valid=0 immediately and no further writes.

Source files
------------

// File: rtl/instr_word_encoder.sv
// Packs decoded instruction fields into 32-bit words and streams them, with addresses,
// through a small FIFO toward instruction memory. Optional ENC_COUNT_EN builds the emitted-word counter.
module instr_word_encoder #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        fmt,
  input  logic [3:0]        fn,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs1,
  input  logic [3:0]        rs2,
  input  logic [15:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              err_flag,
  input  logic              err_clr,
  output logic [7:0]        err_count,
  output logic [15:0]       instr_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          legal, accept, push, pop;
  logic [31:0]   enc_word;

  // Field packing by format; the low byte is always the opcode {fn,fmt}.
  always_comb begin
    legal    = 1'b1;
    enc_word = {24'd0, fn, fmt};
    case (fmt)
      4'b0000, 4'b0010:
        enc_word = {rd, rs1, rs2, 12'd0, fn, fmt};
      4'b1000:
        enc_word = (fn == 4'b1011) ? {rd, 4'd0, imm, fn, fmt} : {rd, rs1, imm, fn, fmt};
      4'b1010, 4'b1001, 4'b1011:
        enc_word = {rd, rs1, imm, fn, fmt};
      4'b0101, 4'b0110:
        enc_word = {rs1, rs2, imm, fn, fmt};
      default:
        legal = 1'b0;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_word  = out_valid ? mem[rd_ptr] : 32'd0;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // in_ready is registered from the post-edge occupancy, so a full FIFO never passes through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt < CW'(FIFO_DEPTH));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  // base_load takes priority over the post-pop increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_addr <= '0;
    end else if (base_load) begin
      out_addr <= base_addr;
    end else if (pop) begin
      out_addr <= out_addr + ADDR_W'(1);
    end
  end

  // A new illegal format outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag  <= 1'b0;
      err_count <= 8'd0;
    end else if (accept && !legal) begin
      err_flag  <= 1'b1;
      if (err_clr)                err_count <= 8'd1;
      else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end else if (err_clr) begin
      err_flag  <= 1'b0;
      err_count <= 8'd0;
    end
  end

`ifdef ENC_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  instr_count <= 16'd0;
    else if (pop)  instr_count <= instr_count + 16'd1;
  end
`else
  assign instr_count = 16'd0;
`endif

endmodule
